debug_trace_buffer: RTL
=======================

# debug_trace_buffer

Parametrised instruction-retire trace recorder for the cpu32e2 debug path. It captures one record per completed machine cycle into a circular buffer. It stops capturing a programmable number of cycles after a breakpoint or forced trigger, then raises a halt request. The frozen history is drained, oldest first, over a valid/ready stream. It sits beside the core, fed from the `debugPkg::debugLines` fields, and its output goes to the debug host interface.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, width of the PC field.
- `DEPTH`, 16, number of records held; power of two, ≥2.
- `POST_TRIGGER`, 4, records captured after the trigger record; range 0..DEPTH-1.
- `BP_COUNT`, 2, number of PC breakpoint comparators; ≥1.
- `STAMP_WIDTH`, 16, width of the retire-count stamp.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `machineCycleDone`  in  1  one retire event per high cycle.
- `nextPC`  in  ADDR_WIDTH  PC written back this cycle.
- `flags`  in  4  flags state.
- `cause`  in  5  exception cause state.
- `arm`  in  1  pulse: clear buffer and start capture.
- `bpAddr`  in  BP_COUNT*ADDR_WIDTH  breakpoint addresses; slot i is at [i*ADDR_WIDTH +: ADDR_WIDTH].
- `bpEnable`  in  BP_COUNT  per-slot enable.
- `forceTrigger`  in  1  software trigger.
- `haltRequest`  out  1  high while FROZEN.
- `rdValid`  out  1  a record is available.
- `rdReady`  in  1  consumer accepts the record.
- `rdData`  out  RECORD_WIDTH  record `{stamp, cause, flags, nextPC}`; RECORD_WIDTH = STAMP_WIDTH+9+ADDR_WIDTH.
- `traceState`  out  2  current state.
- `overflow`  out  1  sticky: at least one record was overwritten since arm.

## Operation
States: IDLE=0, ARMED=1, TRIGGERED=2, FROZEN=3.

- **IDLE:** no capture. `trigger` and `forceTrigger` are ignored.
- **ARMED:** each `machineCycleDone` writes a record at wrPtr and increments wrPtr modulo DEPTH.
  - When count is below DEPTH, count increments.
  - When count == DEPTH, the oldest record is overwritten, rdPtr advances, and `overflow` is set.
- **Trigger condition:** `forceTrigger`, or `machineCycleDone` with `nextPC == bpAddr[i]` and `bpEnable[i]` for any i.
- **ARMED plus trigger:**
  - If `machineCycleDone` is high, the triggering record is written.
  - postCnt is loaded with POST_TRIGGER.
  - The next state is TRIGGERED, or FROZEN directly when POST_TRIGGER = 0.
- **TRIGGERED:** each `machineCycleDone` writes a record and decrements postCnt. The write that takes postCnt 1→0 moves the state to FROZEN. Further triggers are ignored.
- **FROZEN:** no capture; `haltRequest` = 1.
  - `rdValid` = (count ≠ 0).
  - `rdData` = buffer[rdPtr].
  - On `rdValid && rdReady`: rdPtr increments modulo DEPTH and count decrements.
  - The state remains FROZEN when the buffer is empty.
- **Stamp counter:** cleared on arm; increments on every captured `machineCycleDone`; wraps at 2^STAMP_WIDTH. Each record carries the stamp value held before the increment.
- **`arm` in any state:** clears wrPtr, rdPtr, count, stamp, postCnt and `overflow`, and enters ARMED.
  - `arm` has priority over capture, trigger and read in the same cycle.
  - No record is written on the arm cycle.
- **`rdData`** is forced to 0 whenever `rdValid` = 0.

## Timing
- **Reset values:** state IDLE; `haltRequest`, `rdValid`, `overflow`, `traceState` and `rdData` are all 0; pointers, count, stamp and postCnt are 0.
- **Reset mid-operation** discards all buffered records. Memory contents need no clearing, because count = 0 hides them.
- Writes, state changes and pointer updates occur on the `clk` edge where the qualifying input is high.
- **Trigger-to-halt latency:** `haltRequest` and `rdValid` go high in the cycle after the final post-trigger write. With POST_TRIGGER = 0, this is the cycle after the trigger.
- **Read path:** `rdData` is first-word-fall-through from the buffer at rdPtr. Each accepted beat advances the buffer by one record, so one record per cycle is sustained.
- `traceState` is the registered state with no extra delay.

## Structure
- **Package `debugTracePkg`:**
  - `traceStateT` enum (2-bit, with the encodings above).
  - Field-width localparams for cause (5) and flags (4).
  - A function packing `{stamp, cause, flags, pc}`.
- **Sub-module `debug_trace_ram`:** DEPTH×RECORD_WIDTH storage with one synchronous write port and one asynchronous read port.
- **Top level:** the FSM, pointers, count, stamp, postCnt and breakpoint comparators (generate loop over BP_COUNT).

## Test plan
All scenarios use DEPTH=8, POST_TRIGGER=2, BP_COUNT=2 unless stated otherwise.

1. Reset, then 5 `machineCycleDone` pulses without `arm` → `traceState` = 0, `rdValid` = 0, `haltRequest` = 0.
2. `arm`, then retire PCs 0x100, 0x104, …; `bpAddr[0]` = 0x10C enabled → FROZEN one cycle after 0x114 is written. Drain yields 0x100…0x114 with stamps 0…5, then `rdValid` = 0; `overflow` = 0.
3. `arm`, then 12 retires with no trigger, then `forceTrigger` with no retire → 2 more retires, then FROZEN. Drain yields 8 records with stamps 6…13; `overflow` = 1.
4. POST_TRIGGER = 0, and `bpAddr[1]` = 0x200 enabled but `bpEnable[1]` = 0 → no trigger at 0x200. After re-enabling it and re-arming, a retire at 0x200 gives `haltRequest` = 1 on the next cycle, and the last record drained is 0x200.
5. In FROZEN, drain with `rdReady` toggling 1,0,1 → records are popped only on ready cycles, in order. Asserting `arm` together with `rdReady` → no pop, state ARMED, `rdValid` = 0.
6. `reset` asserted in TRIGGERED with postCnt = 1 → next cycle: IDLE, `haltRequest` = 0, `rdValid` = 0; subsequent retires are not captured.

Source files
------------

// File: rtl/debug_trace_buffer_pkg.sv
// Shared types, field widths and record packing for the debug trace buffer.
package debugTracePkg;

  typedef enum logic [1:0] {
    TS_IDLE      = 2'd0,
    TS_ARMED     = 2'd1,
    TS_TRIGGERED = 2'd2,
    TS_FROZEN    = 2'd3
  } traceStateT;

  localparam int unsigned CAUSE_WIDTH      = 5;
  localparam int unsigned FLAGS_WIDTH      = 4;
  localparam int unsigned MAX_FIELD_WIDTH  = 64;
  localparam int unsigned MAX_RECORD_WIDTH = 2 * MAX_FIELD_WIDTH + CAUSE_WIDTH + FLAGS_WIDTH;

  // Pack {stamp, cause, flags, pc} LSB-aligned; caller truncates to its record width.
  function automatic logic [MAX_RECORD_WIDTH-1:0] packRecord(
    input logic [MAX_FIELD_WIDTH-1:0] stamp,
    input logic [CAUSE_WIDTH-1:0]     cause,
    input logic [FLAGS_WIDTH-1:0]     flags,
    input logic [MAX_FIELD_WIDTH-1:0] pc,
    input int unsigned                pcWidth
  );
    logic [MAX_RECORD_WIDTH-1:0] rec;
    rec = MAX_RECORD_WIDTH'(pc);
    rec = rec | (MAX_RECORD_WIDTH'(flags) << pcWidth);
    rec = rec | (MAX_RECORD_WIDTH'(cause) << (pcWidth + FLAGS_WIDTH));
    rec = rec | (MAX_RECORD_WIDTH'(stamp) << (pcWidth + FLAGS_WIDTH + CAUSE_WIDTH));
    return rec;
  endfunction

endpackage

// File: rtl/debug_trace_buffer_ram.sv
// Trace record storage: one synchronous write port, one asynchronous read port.
module debug_trace_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 57,
  localparam int unsigned PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 wrEn,
  input  logic [PTR_WIDTH-1:0] wrAddr,
  input  logic [WIDTH-1:0]     wrData,
  input  logic [PTR_WIDTH-1:0] rdAddr,
  output logic [WIDTH-1:0]     rdData
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Record write on capture cycles
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/debug_trace_buffer.sv
// Circular retire-trace recorder with breakpoint/forced trigger, post-trigger
// capture window, halt request and oldest-first valid/ready drain.
module debug_trace_buffer
  import debugTracePkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned POST_TRIGGER = 4,
  parameter int unsigned BP_COUNT     = 2,
  parameter int unsigned STAMP_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           machineCycleDone,
  input  logic [ADDR_WIDTH-1:0]          nextPC,
  input  logic [FLAGS_WIDTH-1:0]         flags,
  input  logic [CAUSE_WIDTH-1:0]         cause,
  input  logic                           arm,
  input  logic [BP_COUNT*ADDR_WIDTH-1:0] bpAddr,
  input  logic [BP_COUNT-1:0]            bpEnable,
  input  logic                           forceTrigger,
  output logic                           haltRequest,
  output logic                           rdValid,
  input  logic                           rdReady,
  output logic [STAMP_WIDTH+CAUSE_WIDTH+FLAGS_WIDTH+ADDR_WIDTH-1:0] rdData,
  output logic [1:0]                     traceState,
  output logic                           overflow
);

  localparam int unsigned PTR_WIDTH    = $clog2(DEPTH);
  localparam int unsigned CNT_WIDTH    = PTR_WIDTH + 1;
  localparam int unsigned RECORD_WIDTH = STAMP_WIDTH + CAUSE_WIDTH + FLAGS_WIDTH + ADDR_WIDTH;

  traceStateT             state, stateNext;
  logic [PTR_WIDTH-1:0]   wrPtr, wrPtrNext;
  logic [PTR_WIDTH-1:0]   rdPtr, rdPtrNext;
  logic [CNT_WIDTH-1:0]   count, countNext;
  logic [CNT_WIDTH-1:0]   postCnt, postCntNext;
  logic [STAMP_WIDTH-1:0] stamp, stampNext;
  logic                   overflowNext;
  logic                   wrEn;
  logic [BP_COUNT-1:0]    bpMatch;
  logic                   trigger;
  logic [RECORD_WIDTH-1:0] wrRecord;
  logic [RECORD_WIDTH-1:0] ramRdData;

  // Breakpoint comparators, qualified by a retire in the same cycle
  for (genvar i = 0; i < BP_COUNT; i++) begin : gBp
    assign bpMatch[i] = machineCycleDone && bpEnable[i]
                        && (nextPC == bpAddr[i*ADDR_WIDTH +: ADDR_WIDTH]);
  end

  assign trigger  = forceTrigger || (|bpMatch);
  assign wrRecord = RECORD_WIDTH'(packRecord(MAX_FIELD_WIDTH'(stamp), cause, flags,
                                             MAX_FIELD_WIDTH'(nextPC), ADDR_WIDTH));

  debug_trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (RECORD_WIDTH)
  ) uRam (
    .clk    (clk),
    .wrEn   (wrEn),
    .wrAddr (wrPtr),
    .wrData (wrRecord),
    .rdAddr (rdPtr),
    .rdData (ramRdData)
  );

  // State, pointer, count, stamp and overflow registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= TS_IDLE;
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      postCnt  <= '0;
      stamp    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= stateNext;
      wrPtr    <= wrPtrNext;
      rdPtr    <= rdPtrNext;
      count    <= countNext;
      postCnt  <= postCntNext;
      stamp    <= stampNext;
      overflow <= overflowNext;
    end
  end

  // Next-state: arm wins over everything, then capture/trigger/drain per state
  always_comb begin
    stateNext    = state;
    wrPtrNext    = wrPtr;
    rdPtrNext    = rdPtr;
    countNext    = count;
    postCntNext  = postCnt;
    stampNext    = stamp;
    overflowNext = overflow;
    wrEn         = 1'b0;
    if (arm) begin
      stateNext    = TS_ARMED;
      wrPtrNext    = '0;
      rdPtrNext    = '0;
      countNext    = '0;
      postCntNext  = '0;
      stampNext    = '0;
      overflowNext = 1'b0;
    end else begin
      case (state)
        TS_ARMED: begin
          wrEn = machineCycleDone;
          if (trigger) begin
            postCntNext = CNT_WIDTH'(POST_TRIGGER);
            stateNext   = (POST_TRIGGER == 0) ? TS_FROZEN : TS_TRIGGERED;
          end
        end
        TS_TRIGGERED: begin
          if (machineCycleDone) begin
            wrEn        = 1'b1;
            postCntNext = postCnt - CNT_WIDTH'(1);
            if (postCnt == CNT_WIDTH'(1)) begin
              stateNext = TS_FROZEN;
            end
          end
        end
        TS_FROZEN: begin
          if (rdValid && rdReady) begin
            rdPtrNext = rdPtr + PTR_WIDTH'(1);
            countNext = count - CNT_WIDTH'(1);
          end
        end
        default: ;
      endcase
      // A full buffer drops its oldest record to make room
      if (wrEn) begin
        wrPtrNext = wrPtr + PTR_WIDTH'(1);
        stampNext = stamp + STAMP_WIDTH'(1);
        if (count == CNT_WIDTH'(DEPTH)) begin
          rdPtrNext    = rdPtr + PTR_WIDTH'(1);
          overflowNext = 1'b1;
        end else begin
          countNext = count + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign haltRequest = (state == TS_FROZEN);
  assign rdValid     = (state == TS_FROZEN) && (count != '0);
  assign rdData      = rdValid ? ramRdData : '0;
  assign traceState  = state;

endmodule
